// File: rtl/digit_scan_if.sv
// digit_scan_if: digit bus, hold control and segment/frame outputs of the digit scanner.
interface digit_scan_if #(
   parameter int NDIG = 12
);
   logic [5*NDIG-1:0] i_digits;
   logic              i_hold;
   logic [7:0]        o_seg;
   logic              o_frame;
   modport master (output i_digits, i_hold, input o_seg, o_frame);
   modport slave (input i_digits, i_hold, output o_seg, o_frame);
endinterface

// File: rtl/digit_scan.sv
// digit_scan: scans a snapshot of Johnson-coded digits onto one 7-segment display, MSD first, then a blank gap.
// Define DIGIT_SCAN_LZB_EN to blank leading zeros.
module digit_scan #(
   parameter int NDIG  = 12,
   parameter int DWELL = 1000,
   parameter int GAP   = 2000
) (
   input logic         i_clk,
   input logic         i_rst,
   digit_scan_if.slave bus
);
   localparam int CW = $clog2(DWELL > GAP ? DWELL : GAP);
   localparam int IW = $clog2(NDIG);
   localparam logic [CW-1:0] GAP_END   = CW'(GAP - 1);
   localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);
   localparam logic [IW-1:0] IDX_TOP   = IW'(NDIG - 1);
   typedef enum logic {S_GAP, S_SHOW} state_t;
   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [IW-1:0]     idx_q;
   logic [5*NDIG-1:0] shadow_q;
   logic [7:0]        seg_q;
   logic              frame_q;
   logic [4:0]        dig;
   logic [7:0]        code;
   logic [7:0]        seg_d;
   logic              dp;
   logic              blank;
   function automatic logic [7:0] decode(input logic [4:0] c);
      case (c)
         5'b00000: decode = 8'h3F;
         5'b00001: decode = 8'h06;
         5'b00011: decode = 8'h5B;
         5'b00111: decode = 8'h4F;
         5'b01111: decode = 8'h66;
         5'b11111: decode = 8'h6D;
         5'b11110: decode = 8'h7D;
         5'b11100: decode = 8'h07;
         5'b11000: decode = 8'h7F;
         5'b10000: decode = 8'h6F;
         default:  decode = 8'h40;
      endcase
   endfunction
`ifdef DIGIT_SCAN_LZB_EN
   logic [NDIG-1:0] show_q;
   logic [NDIG-1:0] show_d;
   logic            run;
   // A digit is shown once any digit at or above it is nonzero; invalid codes count as nonzero.
   always_comb begin
      show_d = '0;
      run = 1'b0;
      for (int k = NDIG - 1; k >= 0; k--) begin
         run = run | (bus.i_digits[5*k +: 5] != 5'd0);
         show_d[k] = run | (k == 0);
      end
   end
   assign blank = !show_q[idx_q];
`else
   assign blank = 1'b0;
`endif
   always_comb begin
      dig   = shadow_q[5*idx_q +: 5];
      code  = decode(dig);
      dp    = (idx_q == IW'(3)) || (idx_q == IW'(6)) || (idx_q == IW'(9));
      seg_d = blank ? 8'h00 : (code == 8'h40) ? 8'h40 : (code | {dp, 7'b0});
   end
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= S_GAP;
         cnt_q    <= '0;
         idx_q    <= IDX_TOP;
         shadow_q <= '0;
         seg_q    <= 8'h00;
         frame_q  <= 1'b0;
`ifdef DIGIT_SCAN_LZB_EN
         show_q   <= '0;
`endif
      end else if (!bus.i_hold) begin
         frame_q <= 1'b0;
         seg_q   <= (state_q == S_SHOW) ? seg_d : 8'h00;
         case (state_q)
            S_GAP:
               if (cnt_q == GAP_END) begin
                  shadow_q <= bus.i_digits;
`ifdef DIGIT_SCAN_LZB_EN
                  show_q   <= show_d;
`endif
                  idx_q    <= IDX_TOP;
                  cnt_q    <= '0;
                  state_q  <= S_SHOW;
                  frame_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            S_SHOW:
               if (cnt_q == DWELL_END) begin
                  cnt_q <= '0;
                  if (idx_q == '0) state_q <= S_GAP;
                  else idx_q <= idx_q - 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            default: state_q <= S_GAP;
         endcase
      end else begin
         frame_q <= 1'b0;
      end
   end
   assign bus.o_seg   = seg_q;
   assign bus.o_frame = frame_q;
endmodule

// File: tb/tb_digit_scan.sv
// tb_digit_scan: randomized digit_scan bench checked every cycle against a frame-position model.
module tb_digit_scan;
   localparam int NDIG  = 12;
   localparam int DWELL = 4;
   localparam int GAP   = 8;
   localparam int FRAME = GAP + NDIG * DWELL;
   localparam logic [4:0] JC [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                                      5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};
   localparam logic [7:0] SEGS [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
   logic clk;
   logic rst_n;
   logic en;
   int   checks;
   int   errors;
   int   pos;
   logic [5*NDIG-1:0] snap;
   logic [7:0] m_seg;
   logic       m_frame;
   logic [7:0] sl [NDIG];
   logic [7:0] e_zero [NDIG];
   logic [7:0] e_tens [NDIG];
   logic [7:0] e_1234 [NDIG];
   int   n;
   logic [7:0] v;
   digit_scan_if #(.NDIG(NDIG)) bus ();
   digit_scan #(.NDIG(NDIG), .DWELL(DWELL), .GAP(GAP)) dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus)
   );
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   function automatic int jdec(input logic [4:0] c);
      for (int i = 0; i < 10; i++) if (JC[i] == c) return i;
      return -1;
   endfunction
   function automatic logic [5*NDIG-1:0] jnum(input longint unsigned num);
      logic [5*NDIG-1:0] r;
      longint unsigned x;
      r = '0;
      x = num;
      for (int k = 0; k < NDIG; k++) begin
         r[5*k +: 5] = JC[int'(x % 10)];
         x = x / 10;
      end
      return r;
   endfunction
   // What the display must show while the frame sits at position p with snapshot sh.
   function automatic logic [7:0] seg_at(input int p, input logic [5*NDIG-1:0] sh);
      int k;
      int val;
      int top;
      if (p < GAP) return 8'h00;
      k = NDIG - 1 - (p - GAP) / DWELL;
      val = jdec(sh[5*k +: 5]);
      top = 0;
      for (int j = 0; j < NDIG; j++) if (sh[5*j +: 5] != 5'd0) top = j;
`ifdef DIGIT_SCAN_LZB_EN
      if (k > top) return 8'h00;
`endif
      if (val < 0) return 8'h40;
      return SEGS[val] | ((k == 3 || k == 6 || k == 9) ? 8'h80 : 8'h00);
   endfunction
   function automatic logic [5*NDIG-1:0] rnd_digits();
      logic [5*NDIG-1:0] r;
      int z;
      z = $urandom_range(0, NDIG - 1);
      for (int k = 0; k < NDIG; k++)
         r[5*k +: 5] = (k >= NDIG - z) ? 5'd0 :
                       ($urandom_range(0, 9) == 0) ? 5'($urandom) : JC[$urandom_range(0, 9)];
      return r;
   endfunction
   task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos = 0;
         snap = '0;
         m_seg = 8'h00;
         m_frame = 1'b0;
      end else if (!bus.i_hold) begin
         m_seg = seg_at(pos, snap);
         m_frame = (pos == GAP - 1);
         if (pos == GAP - 1) snap = bus.i_digits;
         pos = (pos + 1) % FRAME;
      end else begin
         m_frame = 1'b0;
      end
   end
   always @(negedge clk) begin
      if (en) begin
         chk8("seg", bus.o_seg, m_seg);
         chk8("frame", {7'b0, bus.o_frame}, {7'b0, m_frame});
      end
   end
   // Waits for the frame pulse, then samples the middle of every slot.
   task automatic grab(output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!bus.o_frame && cnt < 200);
      if (cnt >= 200) chk8("frame_timeout", 8'h00, 8'h01);
      for (int s = 0; s < NDIG; s++) begin
         repeat (s == 0 ? 2 : DWELL) @(negedge clk);
         sl[s] = bus.o_seg;
      end
   endtask
   task automatic chk_slots(input string nm, input logic [7:0] e [NDIG]);
      for (int s = 0; s < NDIG; s++) chk8($sformatf("%s_slot%0d", nm, s), sl[s], e[s]);
   endtask
   initial begin
      checks = 0;
      errors = 0;
      en = 1'b0;
      rst_n = 1'b1;
      bus.i_digits = '0;
      bus.i_hold = 1'b0;
`ifdef DIGIT_SCAN_LZB_EN
      e_zero = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F};
      e_tens = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h3F};
      e_1234 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h86, 8'h5B, 8'h4F, 8'h66};
`else
      e_zero = '{8'h3F, 8'h3F, 8'hBF, 8'h3F, 8'h3F, 8'hBF, 8'h3F, 8'h3F, 8'hBF, 8'h3F, 8'h3F, 8'h3F};
      e_tens = '{8'h3F, 8'h3F, 8'hBF, 8'h3F, 8'h3F, 8'hBF, 8'h3F, 8'h3F, 8'hBF, 8'h3F, 8'h40, 8'h3F};
      e_1234 = '{8'h3F, 8'h3F, 8'hBF, 8'h3F, 8'h3F, 8'hBF, 8'h3F, 8'h3F, 8'h86, 8'h5B, 8'h4F, 8'h66};
`endif
      #1 rst_n = 1'b0;
      en = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      grab(n);
      chk8("first_frame_latency", 8'(n), 8'd9);
      chk_slots("zero", e_zero);
      bus.i_digits = '0;
      bus.i_digits[9:5] = 5'b01010;
      grab(n);
      grab(n);
      chk_slots("tens_invalid", e_tens);
      bus.i_digits = jnum(64'd1234);
      grab(n);
      grab(n);
      chk_slots("n1234", e_1234);
      bus.i_digits = '0;
      grab(n);
      repeat (DWELL * (NDIG - 1) + 2) @(negedge clk);
      // Mid-frame change at slot idx5 must not reach the current frame.
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.o_frame && n < 200);
      repeat (1 + DWELL * 6 + 1) @(negedge clk);
      bus.i_digits = jnum(64'd1234);
      repeat (DWELL * 5) @(negedge clk);
      chk8("midframe_old_ones", bus.o_seg, 8'h3F);
      grab(n);
      chk8("midframe_new_ones", sl[NDIG-1], 8'h66);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.o_frame && n < 200);
      repeat (10) @(negedge clk);
      v = bus.o_seg;
      bus.i_hold = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk8("hold_const", bus.o_seg, v);
      end
      bus.i_hold = 1'b0;
      repeat (5) @(negedge clk);
      #3 rst_n = 1'b0;
      #1 chk8("async_rst_seg", bus.o_seg, 8'h00);
      chk8("async_rst_frame", {7'b0, bus.o_frame}, 8'h00);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3000) begin
         @(posedge clk);
         #2;
         bus.i_hold = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 39) == 0) bus.i_digits = rnd_digits();
      end
      @(posedge clk);
      #2 bus.i_hold = 1'b0;
      repeat (2) @(negedge clk);
      en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
